// File: rtl/multicycle_shifter.sv
// Multicycle barrel-free shifter: performs SLL/SRL/SRA one bit per clock.
// A request is latched on acceptance, shifted shamt times in SHIFT, and the
// result is registered on entry to DONE, where a one-cycle done pulse marks it.
module multicycle_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_start_1,
  input  logic [3:0]  in_operation_4,
  input  logic [31:0] in_data_32,
  input  logic [4:0]  in_shamt_5,
  output logic        out_busy_1,
  output logic        out_done_1,
  output logic [31:0] out_result_32,
  output logic        out_zero_1
);

  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [4:0]  count_reg, count_next;
  logic [31:0] work_reg, work_next;
  logic [3:0]  op_reg, op_next;
  logic [31:0] result_reg, result_next;

  logic        accept;
  logic        op_legal;
  logic        is_sll;
  logic        fill_msb;
  logic [31:0] shifted;

  // A new request is taken in IDLE or DONE; SHIFT ignores start entirely.
  assign accept   = in_start_1 && (state_reg != ST_SHIFT);
  assign op_legal = (in_operation_4 == OP_SLL) || (in_operation_4 == OP_SRL) ||
                    (in_operation_4 == OP_SRA);

  // Single-bit shift of the working register, selected by the latched opcode.
  assign is_sll   = (op_reg == OP_SLL);
  assign fill_msb = (op_reg == OP_SRA) ? work_reg[31] : 1'b0;

  assign shifted[0]  = is_sll ? 1'b0 : work_reg[1];
  assign shifted[31] = is_sll ? work_reg[30] : fill_msb;

  genvar gi;
  generate
    for (gi = 1; gi < 31; gi++) begin : g_shift_bit
      assign shifted[gi] = is_sll ? work_reg[gi-1] : work_reg[gi+1];
    end
  endgenerate

  // Next-state logic: shift progress first, then an accepted request overrides.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    work_next   = work_reg;
    op_next     = op_reg;
    result_next = result_reg;

    case (state_reg)
      ST_SHIFT: begin
        work_next  = shifted;
        count_next = count_reg - 5'd1;
        if (count_reg == 5'd1) begin
          state_next  = ST_DONE;
          result_next = shifted;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_IDLE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (accept) begin
      op_next = in_operation_4;
      if (!op_legal) begin
        state_next  = ST_DONE;
        count_next  = 5'd0;
        work_next   = 32'd0;
        result_next = 32'd0;
      end else if (in_shamt_5 == 5'd0) begin
        state_next  = ST_DONE;
        count_next  = 5'd0;
        work_next   = in_data_32;
        result_next = in_data_32;
      end else begin
        state_next = ST_SHIFT;
        count_next = in_shamt_5;
        work_next  = in_data_32;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= 5'd0;
      work_reg   <= 32'd0;
      op_reg     <= 4'd0;
      result_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      work_reg   <= work_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  assign out_busy_1    = (state_reg == ST_SHIFT);
  assign out_done_1    = (state_reg == ST_DONE);
  assign out_result_32 = result_reg;
  assign out_zero_1    = ~|result_reg;

endmodule
